// File: rtl/fp_pkg.sv
// Shared fixed-point definitions for the fp_* arithmetic blocks (fp_div, fp_mult).
// Holds default widths, the divider state encoding and signed-limit helpers.
package fp_pkg;

    localparam int FP_DATA_WIDTH = 32;
    localparam int FP_FRAC_BITS  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp_div_state_e;

    // Largest positive two's-complement value of a w-bit word (w <= 63).
    function automatic logic [63:0] fp_smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative w-bit value; also its magnitude.
    function automatic logic [63:0] fp_smin(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for fp_div.
// master = producer/consumer side, slave = divider side.
interface fp_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] Din0;
    logic [DATA_WIDTH-1:0] Din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Dout;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, Din0, Din1, out_ready,
        input  in_ready, out_valid, Dout, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, Din0, Din1, out_ready,
        output in_ready, out_valid, Dout, div_by_zero, overflow
    );
endinterface

// File: rtl/fp_sat.sv
// Purpose: sign + wide magnitude -> saturated two's-complement word with overflow flag.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
module fp_sat
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = FP_DATA_WIDTH,
    parameter int MAG_WIDTH  = 57
) (
    input  logic                  sign,
    input  logic [MAG_WIDTH-1:0]  mag,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam logic [MAG_WIDTH-1:0]  POS_LIM = MAG_WIDTH'(fp_smax(DATA_WIDTH));
    localparam logic [MAG_WIDTH-1:0]  NEG_LIM = MAG_WIDTH'(fp_smin(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SMAX    = DATA_WIDTH'(fp_smax(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SMIN    = DATA_WIDTH'(fp_smin(DATA_WIDTH));

    // A zero magnitude negates to zero, so no special case is needed for -0.
    always_comb begin
        dout = '0;
        ovf  = 1'b0;
        if (sign) begin
            if (mag > NEG_LIM) begin
                dout = SMIN;
                ovf  = 1'b1;
            end else begin
                dout = -mag[DATA_WIDTH-1:0];
            end
        end else begin
            if (mag > POS_LIM) begin
                dout = SMAX;
                ovf  = 1'b1;
            end else begin
                dout = mag[DATA_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/fp_div.sv
// Purpose: signed fixed-point divider Dout = Din0/Din1, radix-2 restoring, one quotient bit per clock.
// Latency: N+1 edges (N=DATA_WIDTH+FRACTIONAL_BITS), N+2 with FP_DIV_ROUND_EN; divide-by-zero takes 1.
// Backpressure: in_ready only in IDLE, no input buffering; DONE holds the result until out_ready.
module fp_div
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH      = FP_DATA_WIDTH,
    parameter int FRACTIONAL_BITS = FP_FRAC_BITS
) (
    input  logic     Clk,
    input  logic     Reset,
    fp_div_if.slave  bus
);
    localparam int N  = DATA_WIDTH + FRACTIONAL_BITS;
    localparam int CW = $clog2(N);
    localparam logic [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(fp_smax(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(fp_smin(DATA_WIDTH));

    fp_div_state_e         state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [N-1:0]          num, quo, quo_nxt;
    logic [DATA_WIDTH:0]   rem, rem_sh, rem_nxt;
    logic [DATA_WIDTH-1:0] dvs, mag0, mag1, dout_q, sat_dout;
    logic                  sign, dbz_q, ovf_q, qbit, sat_ovf, din1_zero;
    logic [N:0]            sat_mag;

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.Dout        = dout_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

    // Magnitudes are unsigned DATA_WIDTH bits, so the most negative operand does not wrap.
    assign mag0      = bus.Din0[DATA_WIDTH-1] ? -bus.Din0 : bus.Din0;
    assign mag1      = bus.Din1[DATA_WIDTH-1] ? -bus.Din1 : bus.Din1;
    assign din1_zero = (bus.Din1 == '0);

    always_comb begin
        rem_sh  = {rem[DATA_WIDTH-1:0], num[N-1]};
        rem_nxt = rem_sh;
        qbit    = 1'b0;
        if (rem_sh >= {1'b0, dvs}) begin
            rem_nxt = rem_sh - {1'b0, dvs};
            qbit    = 1'b1;
        end
        quo_nxt = {quo[N-2:0], qbit};
    end

`ifdef FP_DIV_ROUND_EN
    // Half away from zero on the magnitude; the sign is applied afterwards.
    logic round_up;
    assign round_up = ({rem, 1'b0} >= {2'b00, dvs});
    assign sat_mag  = {1'b0, quo} + {{N{1'b0}}, round_up};
`else
    assign sat_mag  = {1'b0, quo_nxt};
`endif

    fp_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAG_WIDTH  (N + 1)
    ) u_sat (
        .sign (sign),
        .mag  (sat_mag),
        .dout (sat_dout),
        .ovf  (sat_ovf)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.in_valid) state_nxt = din1_zero ? DONE : CALC;
`ifdef FP_DIV_ROUND_EN
            CALC:  if (cnt == '0) state_nxt = ROUND;
`else
            CALC:  if (cnt == '0) state_nxt = DONE;
`endif
            ROUND: state_nxt = DONE;
            DONE:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt    <= '0;
            num    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            sign   <= 1'b0;
            dout_q <= '0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign <= bus.Din0[DATA_WIDTH-1] ^ bus.Din1[DATA_WIDTH-1];
                    num  <= {mag0, {FRACTIONAL_BITS{1'b0}}};
                    dvs  <= mag1;
                    rem  <= '0;
                    quo  <= '0;
                    cnt  <= CW'(N - 1);
                    if (din1_zero) begin
                        dout_q <= bus.Din0[DATA_WIDTH-1] ? SMIN : SMAX;
                        dbz_q  <= 1'b1;
                        ovf_q  <= 1'b0;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    num <= {num[N-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
`ifndef FP_DIV_ROUND_EN
                    if (cnt == '0) begin
                        dout_q <= sat_dout;
                        ovf_q  <= sat_ovf;
                        dbz_q  <= 1'b0;
                    end
`endif
                end
`ifdef FP_DIV_ROUND_EN
                ROUND: begin
                    dout_q <= sat_dout;
                    ovf_q  <= sat_ovf;
                    dbz_q  <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
